// File: rtl/mem_req_sequencer.sv
// Request sequencer for a single-port 16-deep sync memory: turns valid/ready
// write/read requests into cs/write_en/read_en cycles, captures read data into
// a response register held under backpressure, and counts completed transactions.
module mem_req_sequencer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              wr_done,
  output logic              mem_cs,
  output logic              mem_write_en,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  rd_cnt
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WRITE    = 3'd1;
  localparam logic [2:0] RD_LATCH = 3'd2;
  localparam logic [2:0] RD_DRIVE = 3'd3;
  localparam logic [2:0] RESP     = 3'd4;

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic       accept_c;
  logic       cs_d;
  logic       we_d;
  logic       re_d;
  logic       ready_d;

  // Next-state logic plus decode of the next state into memory-side strobes.
  // Strobes are flopped from the next state so they line up with the state
  // register and never see req_* combinationally.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    cs_d     = 1'b0;
    we_d     = 1'b0;
    re_d     = 1'b0;
    ready_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept_c = 1'b1;
          state_d  = req_we ? WRITE : RD_LATCH;
        end
      end
      WRITE:    state_d = IDLE;
      RD_LATCH: state_d = RD_DRIVE;
      RD_DRIVE: state_d = RESP;
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase
    case (state_d)
      WRITE: begin
        cs_d = 1'b1;
        we_d = 1'b1;
      end
      RD_LATCH: cs_d = 1'b1;
      RD_DRIVE: begin
        cs_d = 1'b1;
        re_d = 1'b1;
      end
      IDLE:     ready_d = 1'b1;
      default: ;
    endcase
  end

  // State register and registered memory strobes; reset drops enables at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_ready    <= 1'b1;
      mem_cs       <= 1'b0;
      mem_write_en <= 1'b0;
      mem_read_en  <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready    <= ready_d;
      mem_cs       <= cs_d;
      mem_write_en <= we_d;
      mem_read_en  <= re_d;
    end
  end

  // Request address/data captured on accept and held for the whole transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (accept_c) begin
      mem_addr  <= req_addr;
      mem_wdata <= req_wdata;
    end
  end

  // Write completion pulse and committed-write counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_done <= 1'b0;
      wr_cnt  <= '0;
    end else begin
      wr_done <= (state_q == WRITE);
      if (state_q == WRITE) wr_cnt <= wr_cnt + CNT_W'(1);
    end
  end

  // Read data capture while the memory drives, held until the master takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rd_cnt    <= '0;
    end else if (state_q == RD_DRIVE) begin
      rsp_valid <= 1'b1;
      rsp_data  <= mem_rdata;
    end else if (state_q == RESP && rsp_ready) begin
      rsp_valid <= 1'b0;
      rd_cnt    <= rd_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_req_sequencer.sv
// Bench for mem_req_sequencer: memory model on the mem_* side, a transaction
// level reference model compared every cycle, and directed scenarios with
// literal expectations.
module tb_mem_req_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_we = 1'b0;
  logic [3:0] req_addr = 4'd0;
  logic [7:0] req_wdata = 8'd0;
  logic       rsp_ready = 1'b1;
  logic       req_ready, rsp_valid, wr_done;
  logic [7:0] rsp_data;
  logic       mem_cs, mem_write_en, mem_read_en;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic [7:0] wr_cnt, rd_cnt;

  logic       req_ready2, rsp_valid2, wr_done2, mem_cs2, mem_we2, mem_re2;
  logic [7:0] rsp_data2, mem_wdata2;
  logic [3:0] mem_addr2;
  logic [1:0] wr_cnt2, rd_cnt2;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b1;

  always #5 clk = ~clk;

  mem_req_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .wr_done(wr_done), .mem_cs(mem_cs), .mem_write_en(mem_write_en),
    .mem_read_en(mem_read_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
  );

  mem_req_sequencer #(.DATA_W(8), .ADDR_W(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready2),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_data(rsp_data2),
    .wr_done(wr_done2), .mem_cs(mem_cs2), .mem_write_en(mem_we2),
    .mem_read_en(mem_re2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_rdata(mem_rdata), .wr_cnt(wr_cnt2), .rd_cnt(rd_cnt2)
  );

  // Sync memory: write on cs&write_en, load holding register on cs only,
  // drive holding register on cs&read_en; otherwise drive junk.
  logic [7:0] env_mem [16];
  logic [7:0] env_hold = 8'd0;
  initial for (int i = 0; i < 16; i++) env_mem[i] = 8'd0;
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_write_en) env_mem[mem_addr] <= mem_wdata;
      else if (!mem_read_en) env_hold <= env_mem[mem_addr];
    end
  end
  assign mem_rdata = (mem_cs && mem_read_en) ? env_hold : 8'hFF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction with its age since accept.
  int         m_busy = 0;      // 0 none, 1 write, 2 read
  int         m_age = 0;
  int         m_wrcnt = 0;
  int         m_rdcnt = 0;
  logic [3:0] m_addr = 4'd0;
  logic [7:0] m_wdata = 8'd0;
  logic       m_rsp_valid = 1'b0;
  logic [7:0] m_rsp_data = 8'd0;
  logic       m_wr_done = 1'b0;
  logic [7:0] m_mem [16];
  initial for (int i = 0; i < 16; i++) m_mem[i] = 8'd0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_age = 0; m_wrcnt = 0; m_rdcnt = 0;
      m_addr = 4'd0; m_wdata = 8'd0; m_rsp_valid = 1'b0;
      m_rsp_data = 8'd0; m_wr_done = 1'b0;
    end else begin
      m_wr_done = 1'b0;
      if (m_busy == 1) begin
        m_mem[m_addr] = m_wdata;
        m_wrcnt++;
        m_wr_done = 1'b1;
        m_busy = 0;
      end else if (m_busy == 2) begin
        if (m_age == 0) m_age = 1;
        else begin
          m_rsp_valid = 1'b1;
          m_rsp_data = m_mem[m_addr];
          m_busy = 0;
        end
      end else if (m_rsp_valid) begin
        if (rsp_ready) begin
          m_rsp_valid = 1'b0;
          m_rdcnt++;
        end
      end else if (req_valid) begin
        m_addr = req_addr;
        m_wdata = req_wdata;
        m_busy = req_we ? 1 : 2;
        m_age = 0;
      end
    end
  end

  // Per-cycle comparison against the model (reset state while rst_n is low).
  always @(negedge clk) begin
    if (chk_en) begin
      if (!rst_n) begin
        check("rst_mem_cs", 32'(mem_cs), 32'd0);
        check("rst_mem_en", 32'({mem_write_en, mem_read_en}), 32'd0);
        check("rst_rsp", 32'({rsp_valid, rsp_data}), 32'd0);
        check("rst_wr_done", 32'(wr_done), 32'd0);
        check("rst_mem_addr_data", 32'({mem_addr, mem_wdata}), 32'd0);
        check("rst_cnts", 32'({wr_cnt, rd_cnt}), 32'd0);
      end else begin
        check("req_ready", 32'(req_ready), 32'(m_busy == 0 && !m_rsp_valid));
        check("mem_cs", 32'(mem_cs), 32'(m_busy != 0));
        check("mem_write_en", 32'(mem_write_en), 32'(m_busy == 1));
        check("mem_read_en", 32'(mem_read_en), 32'(m_busy == 2 && m_age == 1));
        check("mem_addr", 32'(mem_addr), 32'(m_addr));
        check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
        check("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
        check("rsp_data", 32'(rsp_data), 32'(m_rsp_data));
        check("wr_done", 32'(wr_done), 32'(m_wr_done));
        check("wr_cnt", 32'(wr_cnt), 32'(m_wrcnt % 256));
        check("rd_cnt", 32'(rd_cnt), 32'(m_rdcnt % 256));
        check("wr_cnt2", 32'(wr_cnt2), 32'(m_wrcnt % 4));
      end
    end
  end

  // Present a request at the current negedge, hold until accepted, then drop.
  task automatic send(input logic we, input logic [3:0] a, input logic [7:0] d);
    int n;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("accept_timeout", 32'(n), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Read and wait (bounded) for the response; returns negedges waited after accept.
  task automatic do_read(input logic [3:0] a, input logic [7:0] exp, input string name);
    int lat;
    send(1'b0, a, 8'd0);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'd2);
    check({name, "_data"}, 32'(rsp_data), 32'(exp));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [7:0] wdat [4];
  logic [1:0] cnt2_exp [5];

  initial begin : stim
    wdat[0] = 8'h8A; wdat[1] = 8'hEA; wdat[2] = 8'hCE; wdat[3] = 8'hAA;
    cnt2_exp[0] = 2'd1; cnt2_exp[1] = 2'd2; cnt2_exp[2] = 2'd3;
    cnt2_exp[3] = 2'd0; cnt2_exp[4] = 2'd1;

    // Reset for two cycles, release at a negedge.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_req_ready", 32'(req_ready), 32'd1);
    check("post_reset_wr_cnt", 32'(wr_cnt), 32'd0);

    // Back-to-back writes.
    for (int i = 0; i < 4; i++) send(1'b1, 4'(i), wdat[i]);
    @(negedge clk);
    check("writes_wr_cnt", 32'(wr_cnt), 32'd4);

    // Reads with rsp_ready high.
    rsp_ready = 1'b1;
    do_read(4'd0, 8'h8A, "rd0");
    do_read(4'd1, 8'hEA, "rd1");
    do_read(4'd2, 8'hCE, "rd2");
    do_read(4'd3, 8'hAA, "rd3");
    @(negedge clk);
    check("reads_rd_cnt", 32'(rd_cnt), 32'd4);

    // Backpressure: response held, pending request ignored.
    rsp_ready = 1'b0;
    do_read(4'd2, 8'hCE, "bp");
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd5; req_wdata = 8'h77;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_data", 32'(rsp_data), 32'hCE);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_rd_cnt", 32'(rd_cnt), 32'd4);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_rd_cnt", 32'(rd_cnt), 32'd5);
    check("bp_release_rsp_valid", 32'(rsp_valid), 32'd0);

    // Reset pulsed in the middle of a write cycle.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd1; req_wdata = 8'h55;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    check("async_cs_drop", 32'({mem_cs, mem_write_en}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midwr_wr_cnt", 32'(wr_cnt), 32'd0);
    do_read(4'd1, 8'hEA, "midwr_rd1");
    @(negedge clk);

    // Narrow counter wrap on the CNT_W=2 instance.
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 4'(8 + i), 8'(8'h10 + i));
      @(negedge clk);
      check("cnt2_wrap", 32'(wr_cnt2), 32'(cnt2_exp[i]));
    end
    check("cnt8_after5", 32'(wr_cnt), 32'd5);
    do_read(4'd11, 8'h13, "rd11");
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
